pe_mac_ctrl: RTL and testbench

Per-PE MAC sequencer that drives the gated multiplier inside each processing element. It walks the filter and ifmap scratchpads for one dot product and feeds both operands to the multiplier. It drives the multiplier's gate, skipping the multiply whenever either operand is zero, and accumulates the products onto an incoming partial sum. The finished psum is returned on a valid/ready port toward the psum spad or the next PE.

---
 rtl/pe_mac_ctrl.sv | 136 +++++++++++++
 tb/tb_pe_mac_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_mac_ctrl.sv
// pe_mac_ctrl -- per-PE MAC sequencer.
//
// Walks the filter and ifmap scratchpads for one dot product of N taps
// (N = cfg_len + 1). Each tap's operands go to an external gated
// multiplier. The products are accumulated onto an initial partial sum,
// and the result is returned on a valid/ready port.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   start         begin a job (sampled only in IDLE)
//   cfg_len       taps minus one, latched on start
//   psum_in       initial accumulator value, latched on start
//   busy          high from the cycle after start until the output handshake
//   filter_addr   filter spad read address (1-cycle synchronous read)
//   ifmap_addr    ifmap spad read address (1-cycle synchronous read)
//   filter_data   filter spad read data
//   ifmap_data    ifmap spad read data
//   mul_gate      multiplier gate: 1 = forced-zero product, 0 = multiply
//   mul_result    multiplier product (combinational from operands)
//   psum_out      finished partial sum (registered)
//   psum_valid    psum_out valid
//   psum_ready    consumer accepts psum_out
//   skip_cnt      number of gated taps in the current or last job
module pe_mac_ctrl #(
  parameter int FILTER_SIZE = 8,
  parameter int IFMAP_SIZE  = 8,
  parameter int PSUM_SIZE   = 32,
  parameter int ADDR_W      = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [ADDR_W-1:0]           cfg_len,
  input  logic signed [PSUM_SIZE-1:0] psum_in,
  output logic                        busy,
  output logic [ADDR_W-1:0]           filter_addr,
  output logic [ADDR_W-1:0]           ifmap_addr,
  input  logic [FILTER_SIZE-1:0]      filter_data,
  input  logic [IFMAP_SIZE-1:0]       ifmap_data,
  output logic                        mul_gate,
  input  logic signed [PSUM_SIZE-1:0] mul_result,
  output logic signed [PSUM_SIZE-1:0] psum_out,
  output logic                        psum_valid,
  input  logic                        psum_ready,
  output logic [ADDR_W:0]             skip_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t                      state;
  logic [ADDR_W-1:0]           len;
  logic [ADDR_W-1:0]           idx;
  logic                        rd_vld;
  logic signed [PSUM_SIZE-1:0] acc;
  logic signed [PSUM_SIZE-1:0] acc_next;
  logic                        zero_op;

  // A tap is skipped when either operand is zero. The gated multiplier then
  // returns 0, so the accumulated result matches the full computation.
  assign zero_op  = (filter_data == '0) || (ifmap_data == '0);
  assign mul_gate = !rd_vld || zero_op;

  // Accumulation wraps modulo 2^PSUM_SIZE.
  assign acc_next = acc + (rd_vld ? mul_result : '0);

  // idx is the registered read address. It is zeroed on leaving RUN, so
  // the address rests at 0 outside RUN.
  assign filter_addr = idx;
  assign ifmap_addr  = idx;

  // NOTE: all state is updated with non-blocking assignments. Every
  // register then sees pre-edge values, whatever the statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      len        <= '0;
      idx        <= '0;
      rd_vld     <= 1'b0;
      acc        <= '0;
      busy       <= 1'b0;
      psum_out   <= '0;
      psum_valid <= 1'b0;
      skip_cnt   <= '0;
    end else begin
      // Spad data is live the cycle after an address is issued in RUN.
      rd_vld <= (state == RUN);

      if (rd_vld) begin
        acc <= acc_next;
        if (zero_op) skip_cnt <= skip_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            len      <= cfg_len;
            acc      <= psum_in;
            idx      <= '0;
            skip_cnt <= '0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          // Stop at len, so cfg_len all ones never wraps idx.
          if (idx == len) begin
            idx   <= '0;
            state <= DRAIN;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DRAIN: begin
          // The last tap's data is live now. Capture the sum including it.
          psum_out   <= acc_next;
          psum_valid <= 1'b1;
          state      <= OUT;
        end
        OUT: begin
          if (psum_ready) begin
            psum_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_mac_ctrl.sv
// tb_pe_mac_ctrl -- directed, self-checking bench for pe_mac_ctrl.
// The bench models the two spads (1-cycle synchronous read) and the gated
// multiplier. An expected result is queued when each job starts and
// compared when the DUT presents psum_valid.
module tb_pe_mac_ctrl;

  localparam int FS = 8;
  localparam int IS = 8;
  localparam int PS = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] cfg_len;
  logic [PS-1:0] psum_in;
  logic          busy;
  logic [AW-1:0] filter_addr;
  logic [AW-1:0] ifmap_addr;
  logic [FS-1:0] filter_data;
  logic [IS-1:0] ifmap_data;
  logic          mul_gate;
  logic [PS-1:0] mul_result;
  logic [PS-1:0] psum_out;
  logic          psum_valid;
  logic          psum_ready;
  logic [AW:0]   skip_cnt;

  pe_mac_ctrl #(
    .FILTER_SIZE(FS), .IFMAP_SIZE(IS), .PSUM_SIZE(PS), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len),
    .psum_in(psum_in), .busy(busy), .filter_addr(filter_addr),
    .ifmap_addr(ifmap_addr), .filter_data(filter_data),
    .ifmap_data(ifmap_data), .mul_gate(mul_gate), .mul_result(mul_result),
    .psum_out(psum_out), .psum_valid(psum_valid), .psum_ready(psum_ready),
    .skip_cnt(skip_cnt)
  );

  always #5 clk = ~clk;

  // Scratchpad models: 1-cycle synchronous read.
  logic [FS-1:0] filt_mem [16];
  logic [IS-1:0] ifm_mem  [16];

  always @(posedge clk) begin
    filter_data <= filt_mem[filter_addr];
    ifmap_data  <= ifm_mem[ifmap_addr];
  end

  // Gated multiplier model: signed product, forced to 0 when gated.
  logic signed [PS-1:0] fa, ia;
  always_comb begin
    fa = $signed(filter_data);
    ia = $signed(ifmap_data);
    mul_result = mul_gate ? '0 : PS'(fa * ia);
  end

  typedef struct packed {
    logic [PS-1:0] psum;
    logic [AW:0]   skip;
  } exp_t;

  exp_t sb_q [$];
  int tests  = 0;
  int failed = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input int n, input logic [PS-1:0] pin);
    exp_t e;
    logic signed [PS-1:0] a, b;
    e.psum = pin;
    e.skip = '0;
    for (int i = 0; i < n; i++) begin
      a = $signed(filt_mem[i]);
      b = $signed(ifm_mem[i]);
      if (filt_mem[i] == '0 || ifm_mem[i] == '0) e.skip = e.skip + 1'b1;
      e.psum = e.psum + PS'(a * b);
    end
    return e;
  endfunction

  function automatic logic exp_gate(input int i);
    return (filt_mem[i] == '0) || (ifm_mem[i] == '0);
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_valid"}, psum_valid, 0);
    check({tag, "_faddr"}, filter_addr, 0);
    check({tag, "_iaddr"}, ifmap_addr, 0);
    check({tag, "_psum"},  psum_out, 0);
    check({tag, "_skip"},  skip_cnt, 0);
    check({tag, "_gate"},  mul_gate, 1);
  endtask

  // Drive start for one cycle in IDLE. Afterwards cfg_len/psum_in are
  // scrambled so that a failure to latch them shows up.
  task automatic start_job(input logic [AW-1:0] len, input logic [PS-1:0] pin, input bit push);
    start   = 1'b1;
    cfg_len = len;
    psum_in = pin;
    if (push) sb_q.push_back(model(int'(len) + 1, pin));
    tick();
    start   = 1'b0;
    cfg_len = ~len;
    psum_in = 32'hDEAD_BEEF;
    check("busy_after_start", busy, 1);
  endtask

  // Called in cycle t+1. Returns in cycle t+n+2, where psum_valid must be high.
  task automatic run_to_valid(input int n);
    for (int k = 1; k <= n + 2; k++) begin
      if (k <= n) begin
        check($sformatf("faddr_k%0d", k), filter_addr, k - 1);
        check($sformatf("iaddr_k%0d", k), ifmap_addr, k - 1);
      end
      if (k == 1) check("gate_no_data", mul_gate, 1);
      else if (k <= n + 1) check($sformatf("gate_tap%0d", k - 2), mul_gate, exp_gate(k - 2));
      if (k == n + 1) check("valid_early", psum_valid, 0);
      if (k == n + 2) check("valid_latency", psum_valid, 1);
      else tick();
    end
  endtask

  task automatic check_result();
    exp_t e;
    check("sb_nonempty", sb_q.size() > 0, 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("psum_out", psum_out, e.psum);
      check("skip_cnt", skip_cnt, e.skip);
    end
  endtask

  // With psum_ready high in the valid cycle, the next cycle is IDLE.
  task automatic finish_handshake();
    tick();
    check("valid_drop", psum_valid, 0);
    check("busy_drop", busy, 0);
  endtask

  task automatic load4(input logic [FS-1:0] f0, f1, f2, f3,
                       input logic [IS-1:0] i0, i1, i2, i3);
    filt_mem[0] = f0; filt_mem[1] = f1; filt_mem[2] = f2; filt_mem[3] = f3;
    ifm_mem[0]  = i0; ifm_mem[1]  = i1; ifm_mem[2]  = i2; ifm_mem[3]  = i3;
  endtask

  exp_t held;

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    cfg_len    = '0;
    psum_in    = '0;
    psum_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      filt_mem[i] = '0;
      ifm_mem[i]  = '0;
    end

    repeat (3) tick();
    check_reset_vals("rst");
    rst = 1'b0;
    tick();
    check_reset_vals("idle");

    // Basic job: 10 + 5 + 12 + 21 + 32 = 80, no skips.
    load4(1, 2, 3, 4, 5, 6, 7, 8);
    start_job(3, 10, 1);
    run_to_valid(4);
    check_result();
    finish_handshake();

    // Zero skip, started back-to-back: 12 + 32 = 44, two gated taps.
    load4(0, 2, 0, 4, 5, 6, 7, 8);
    start_job(3, 0, 1);
    run_to_valid(4);
    check_result();
    finish_handshake();

    // Signed product with N = 1: -128 * 127 = -16256.
    filt_mem[0] = 8'h80;
    ifm_mem[0]  = 8'h7F;
    start_job(0, 0, 1);
    run_to_valid(1);
    check_result();
    finish_handshake();

    // Wrap: 0x7FFFFFFF + 1 = 0x80000000.
    filt_mem[0] = 8'd1;
    ifm_mem[0]  = 8'd1;
    start_job(0, 32'h7FFF_FFFF, 1);
    run_to_valid(1);
    check_result();
    finish_handshake();

    // Backpressure: OUT held for 5 cycles, with start pulsed there (ignored).
    load4(1, 2, 3, 4, 5, 6, 7, 8);
    psum_ready = 1'b0;
    start_job(3, 5, 1);
    run_to_valid(4);
    held = sb_q[0];
    for (int c = 0; c < 5; c++) begin
      start   = 1'b1;
      cfg_len = 4'd0;
      psum_in = 32'd1;
      tick();
      check($sformatf("hold_valid_c%0d", c), psum_valid, 1);
      check($sformatf("hold_busy_c%0d", c), busy, 1);
      check($sformatf("hold_psum_c%0d", c), psum_out, held.psum);
      check($sformatf("hold_skip_c%0d", c), skip_cnt, held.skip);
    end
    start      = 1'b0;
    psum_ready = 1'b1;
    check_result();
    finish_handshake();
    // Start in the first IDLE cycle after release.
    start_job(3, 100, 1);
    run_to_valid(4);
    check_result();
    finish_handshake();

    // Reset mid-RUN at idx = 2 of an N = 8 job.
    for (int i = 0; i < 8; i++) begin
      filt_mem[i] = FS'(i + 1);
      ifm_mem[i]  = IS'(2 * i + 1);
    end
    start_job(7, 3, 0);
    tick();
    tick();
    check("midrun_idx2", filter_addr, 2);
    rst = 1'b1;
    tick();
    check_reset_vals("midrun_rst");
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      check($sformatf("aborted_no_valid_c%0d", c), psum_valid, 0);
    end
    start_job(7, 3, 1);
    run_to_valid(8);
    check_result();
    finish_handshake();

    // Full depth: 16 taps of 1*1 -> 16, valid at t+18.
    for (int i = 0; i < 16; i++) begin
      filt_mem[i] = 8'd1;
      ifm_mem[i]  = 8'd1;
    end
    start_job(15, 0, 1);
    run_to_valid(16);
    check_result();
    finish_handshake();

    // Full depth, all-zero filter -> 0, skip_cnt = 16.
    for (int i = 0; i < 16; i++) filt_mem[i] = '0;
    start_job(15, 0, 1);
    run_to_valid(16);
    check_result();
    finish_handshake();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
